// File: rtl/l1_carry_resolve.sv
// Resolves one redundant L1 word (overlapping-carry limbs) into a canonical binary
// integer by rippling the carry through one limb per clock.
module l1_carry_resolve #(
   parameter int N_LIMB = 4,
   parameter int STRIDE = 72,
   parameter int LIMB_W = 76,
   parameter int TAG_W  = 3
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_LIMB*LIMB_W-1:0]   din,
   input  logic [TAG_W-1:0]           tag_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_LIMB*STRIDE+LIMB_W-STRIDE:0] dout,
   output logic [TAG_W-1:0]           tag_out,
   output logic                       busy
);

   localparam int CW    = LIMB_W - STRIDE + 1;
   localparam int OUT_W = N_LIMB * STRIDE + CW;
   localparam int KW    = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PROP, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic [KW-1:0]               k_q, k_d;
   logic [CW-1:0]               c_q, c_d;
   logic [N_LIMB*LIMB_W-1:0]    buf_q, buf_d;
   logic [TAG_W-1:0]            tag_q, tag_d;
   logic [OUT_W-1:0]            dout_q, dout_d;
   logic                        rdy_q, rdy_d;
   logic [LIMB_W-1:0]           limb;
   logic [LIMB_W:0]             sum;

   assign in_ready  = rdy_q && (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_PROP) || (state_q == S_DONE);
   assign dout      = dout_q;
   assign tag_out   = tag_q;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      c_d     = c_q;
      buf_d   = buf_q;
      tag_d   = tag_q;
      dout_d  = dout_q;
      rdy_d   = 1'b1;

      limb = '0;
      for (int i = 0; i < N_LIMB; i++) begin
         if (int'(k_q) == i) limb = buf_q[i*LIMB_W +: LIMB_W];
      end
      sum = {1'b0, limb} + (LIMB_W+1)'(c_q);

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               buf_d   = din;
               tag_d   = tag_in;
               dout_d  = '0;
               c_d     = '0;
               k_d     = '0;
               state_d = S_PROP;
            end
         end
         S_PROP: begin
            for (int i = 0; i < N_LIMB; i++) begin
               if (int'(k_q) == i) dout_d[i*STRIDE +: STRIDE] = sum[STRIDE-1:0];
            end
            c_d = sum[LIMB_W:STRIDE];
            // The last limb's carry out lands directly in the top field, so no extra cycle is needed.
            if (k_q == KW'(N_LIMB - 1)) begin
               dout_d[N_LIMB*STRIDE +: CW] = sum[LIMB_W:STRIDE];
               k_d     = '0;
               state_d = S_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         c_q     <= '0;
         buf_q   <= '0;
         tag_q   <= '0;
         dout_q  <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         c_q     <= c_d;
         buf_q   <= buf_d;
         tag_q   <= tag_d;
         dout_q  <= dout_d;
         rdy_q   <= rdy_d;
      end
   end

endmodule

// File: tb/tb_l1_carry_resolve.sv
// Directed and pseudo-random checks of l1_carry_resolve against a wide-integer
// reference sum of the limbs.
module tb_l1_carry_resolve;

   localparam int N_LIMB = 4;
   localparam int STRIDE = 72;
   localparam int LIMB_W = 76;
   localparam int TAG_W  = 3;
   localparam int CW     = LIMB_W - STRIDE + 1;
   localparam int OUT_W  = N_LIMB * STRIDE + CW;
   localparam int DIN_W  = N_LIMB * LIMB_W;

   logic               clk;
   logic               rstn;
   logic               in_valid;
   logic               in_ready;
   logic [DIN_W-1:0]   din;
   logic [TAG_W-1:0]   tag_in;
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   dout;
   logic [TAG_W-1:0]   tag_out;
   logic               busy;

   int vectorCount = 0;
   int missCount   = 0;

   l1_carry_resolve #(
      .N_LIMB(N_LIMB), .STRIDE(STRIDE), .LIMB_W(LIMB_W), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .din(din), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .tag_out(tag_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer sum of limb_i shifted by i*STRIDE.
   function automatic logic [OUT_W-1:0] refSum(input logic [DIN_W-1:0] d);
      logic [OUT_W-1:0] r;
      r = '0;
      for (int i = 0; i < N_LIMB; i++) begin
         r = r + (OUT_W'(d[i*LIMB_W +: LIMB_W]) << (i*STRIDE));
      end
      return r;
   endfunction

   function automatic logic [LIMB_W-1:0] randLimb();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[LIMB_W-1:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
      vectorCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents a word, waits for acceptance and for the result, and checks latency and value.
   task automatic applyStimulus(input logic [DIN_W-1:0] d, input logic [TAG_W-1:0] t, input string name);
      logic acc;
      int   lat;
      din      = d;
      tag_in   = t;
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int w = 0; w < 20 && !acc; w++) begin
         if (in_ready) acc = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checkOutput({name, "_accept"}, OUT_W'(acc), OUT_W'(1));
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({name, "_latency"}, OUT_W'(lat), OUT_W'(N_LIMB));
      checkOutput({name, "_dout"}, dout, refSum(d));
      checkOutput({name, "_tag"}, OUT_W'(tag_out), OUT_W'(t));
   endtask

   task automatic finishHandshake(input string name);
      @(posedge clk); #1;
      checkOutput({name, "_vld_drop"}, OUT_W'(out_valid), OUT_W'(0));
      checkOutput({name, "_rdy_back"}, OUT_W'(in_ready), OUT_W'(1));
   endtask

   logic [DIN_W-1:0]  w;
   logic [DIN_W-1:0]  words [3];
   logic [TAG_W-1:0]  tags  [3];
   logic [LIMB_W-1:0] ones;
   logic [OUT_W-1:0]  top;

   initial begin
      rstn = 1'b0; in_valid = 1'b0; din = '0; tag_in = '0; out_ready = 1'b1;
      ones = '1;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", OUT_W'(in_ready), OUT_W'(0));
      checkOutput("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
      checkOutput("rst_busy", OUT_W'(busy), OUT_W'(0));
      checkOutput("rst_dout", dout, OUT_W'(0));
      checkOutput("rst_tag", OUT_W'(tag_out), OUT_W'(0));
      rstn = 1'b1;
      @(posedge clk); #1;
      checkOutput("post_rst_ready", OUT_W'(in_ready), OUT_W'(1));

      // Single bit at weight 2^72 sits in limb 0's overlap bits.
      w = '0;
      w[72] = 1'b1;
      applyStimulus(w, 3'd5, "single");
      checkOutput("single_hand", dout, OUT_W'(1) << 72);
      finishHandshake("single");

      w = {N_LIMB{ones}};
      applyStimulus(w, 3'd2, "fullcarry");
      top = OUT_W'(dout[OUT_W-1 -: CW]);
      checkOutput("fullcarry_top", top, OUT_W'(16));
      finishHandshake("fullcarry");

      $display("[TB] backpressure");
      out_ready = 1'b0;
      w = {randLimb(), randLimb(), randLimb(), randLimb()};
      applyStimulus(w, 3'd3, "bp");
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         din      = ~w;
         tag_in   = 3'd6;
         checkOutput("bp_valid", OUT_W'(out_valid), OUT_W'(1));
         checkOutput("bp_in_ready", OUT_W'(in_ready), OUT_W'(0));
         checkOutput("bp_dout", dout, refSum(w));
         checkOutput("bp_tag", OUT_W'(tag_out), OUT_W'(3));
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("bp_still_valid", OUT_W'(out_valid), OUT_W'(1));
      finishHandshake("bp");
      checkOutput("bp_idle", OUT_W'(busy), OUT_W'(0));
      @(posedge clk); #1;
      checkOutput("bp_not_consumed", OUT_W'(busy), OUT_W'(0));

      $display("[TB] mid-operation reset");
      w = {randLimb(), randLimb(), randLimb(), randLimb()};
      din = w; tag_in = 3'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("mrst_in_prop", OUT_W'(busy), OUT_W'(1));
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      checkOutput("mrst_valid", OUT_W'(out_valid), OUT_W'(0));
      checkOutput("mrst_dout", dout, OUT_W'(0));
      checkOutput("mrst_busy", OUT_W'(busy), OUT_W'(0));
      checkOutput("mrst_ready_low", OUT_W'(in_ready), OUT_W'(0));
      @(posedge clk); #1;
      checkOutput("mrst_ready", OUT_W'(in_ready), OUT_W'(1));
      w = {randLimb(), randLimb(), randLimb(), randLimb()};
      applyStimulus(w, 3'd1, "mrst_after");
      finishHandshake("mrst_after");

      $display("[TB] back-to-back");
      for (int i = 0; i < 3; i++) begin
         words[i] = {randLimb(), randLimb(), randLimb(), randLimb()};
         tags[i]  = TAG_W'(i + 4);
      end
      begin
         int cyc, idxIn, idxOut, lastOut;
         logic acceptNow;
         cyc = 0; idxIn = 0; idxOut = 0; lastOut = 0;
         din = words[0]; tag_in = tags[0]; in_valid = 1'b1;
         while (idxOut < 3 && cyc < 60) begin
            if (out_valid && out_ready) begin
               checkOutput("b2b_dout", dout, refSum(words[idxOut]));
               checkOutput("b2b_tag", OUT_W'(tag_out), OUT_W'(tags[idxOut]));
               if (idxOut > 0) checkOutput("b2b_spacing", OUT_W'(cyc - lastOut), OUT_W'(N_LIMB + 2));
               lastOut = cyc;
               idxOut++;
            end
            acceptNow = in_ready && in_valid;
            @(posedge clk); #1;
            cyc++;
            if (acceptNow) begin
               idxIn++;
               if (idxIn < 3) begin
                  din = words[idxIn]; tag_in = tags[idxIn];
               end else begin
                  in_valid = 1'b0;
                  din = '1;
               end
            end
         end
         checkOutput("b2b_count", OUT_W'(idxOut), OUT_W'(3));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      $display("[TB] random");
      for (int n = 0; n < 200 && missCount == 0; n++) begin
         w = {randLimb(), randLimb(), randLimb(), randLimb()};
         if (n % 16 == 0) w[LIMB_W-1:0] = ones;
         applyStimulus(w, TAG_W'($urandom_range(0, 7)), "rand");
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
